timer_ctrl: RTL and testbench

Countdown-timer controller for the MM:SS seven-segment timer. It generates its own single-cycle tick enables from the system clock and sequences a BCD minutes/seconds countdown through an IDLE/RUN/PAUSE/DONE state machine. It also schedules the 4-digit anode scan. It sits between the debounced button pulses and the seven-segment decoder, and replaces free-running derived clocks with clock-enable strobes.

---
 rtl/timer_pkg.sv | 50 +++++
 rtl/tick_gen.sv | 38 +++
 rtl/timer_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_timer_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer: FSM states,
// anode patterns, BCD limits and the BCD clamp/decrement helpers.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] AN_SS_ONES = 4'b1110;
    localparam logic [3:0] AN_SS_TENS = 4'b1101;
    localparam logic [3:0] AN_MM_ONES = 4'b1011;
    localparam logic [3:0] AN_MM_TENS = 4'b0111;
    localparam logic [3:0] AN_BLANK   = 4'b1111;

    localparam logic [3:0] BCD_MAX_DIGIT    = 4'd9;
    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

    // Clamp each nibble to a legal BCD digit; the tens nibble gets its own ceiling.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic [3:0] tens_max);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (v[7:4] > tens_max) ? tens_max : v[7:4];
        ones = (v[3:0] > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : v[3:0];
        return {tens, ones};
    endfunction

    function automatic logic [15:0] bcd_dec_mmss(input logic [7:0] mm, input logic [7:0] ss);
        logic [7:0] mm_n;
        logic [7:0] ss_n;
        mm_n = mm;
        ss_n = ss;
        if (ss[3:0] != 4'd0) begin
            ss_n[3:0] = ss[3:0] - 4'd1;
        end else if (ss[7:4] != 4'd0) begin
            ss_n = {ss[7:4] - 4'd1, BCD_MAX_DIGIT};
        end else begin
            ss_n = {BCD_MAX_SEC_TENS, BCD_MAX_DIGIT};
            if (mm[3:0] != 4'd0) begin
                mm_n[3:0] = mm[3:0] - 4'd1;
            end else begin
                mm_n = {mm[7:4] - 4'd1, BCD_MAX_DIGIT};
            end
        end
        return {mm_n, ss_n};
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable prescaler: counts 0..DIV-1 while enabled and strobes tick
// for one cycle on the terminal count. clr restarts the count from zero.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TERM = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == TERM);

endmodule

// File: rtl/timer_ctrl.sv
// MM:SS countdown controller with IDLE/RUN/PAUSE/DONE sequencing and a
// 4-digit anode scan. Define TIMER_DONE_BLINK_EN to blink the display in DONE.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int SCAN_HZ = 400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic [3:0] an,
    output logic [3:0] digit,
    output logic       running,
    output logic       done
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;

    if (CLK_HZ % TICK_HZ != 0) begin : g_bad_tick_ratio
        $error("timer_ctrl: CLK_HZ must be an exact multiple of TICK_HZ");
    end
    if (CLK_HZ % SCAN_HZ != 0) begin : g_bad_scan_ratio
        $error("timer_ctrl: CLK_HZ must be an exact multiple of SCAN_HZ");
    end

    state_e     state_q, state_d;
    logic [7:0] mm_q, mm_d;
    logic [7:0] ss_q, ss_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] an_q, an_d;
    logic [3:0] digit_q, digit_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       tick;
    logic       scan_tick;
    logic       tick_clr;
    logic [15:0] dec_val;
    logic [7:0] load_mm_clean;
    logic [7:0] load_ss_clean;
    logic       blank;

    assign dec_val       = bcd_dec_mmss(mm_q, ss_q);
    assign load_mm_clean = bcd_clamp(load_mm, BCD_MAX_DIGIT);
    assign load_ss_clean = bcd_clamp(load_ss, BCD_MAX_SEC_TENS);
    // Restart the countdown phase on every entry to RUN.
    assign tick_clr      = (state_d == RUN) && (state_q != RUN);

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .clr   (tick_clr),
        .tick  (tick)
    );

    tick_gen #(.DIV(SCAN_DIV)) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .tick  (scan_tick)
    );

    always_comb begin
        state_d = state_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    mm_d = 8'h00;
                    ss_d = 8'h00;
                end else if (load) begin
                    mm_d = load_mm_clean;
                    ss_d = load_ss_clean;
                end else if (start && ({mm_q, ss_q} != 16'h0000)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clear) begin
                    state_d = IDLE;
                    mm_d    = 8'h00;
                    ss_d    = 8'h00;
                end else if (pause) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    {mm_d, ss_d} = dec_val;
                    if (dec_val == 16'h0000) begin
                        state_d = DONE;
                    end
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_d = IDLE;
                    mm_d    = 8'h00;
                    ss_d    = 8'h00;
                end else if (load) begin
                    state_d = IDLE;
                    mm_d    = load_mm_clean;
                    ss_d    = load_ss_clean;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (clear) begin
                    state_d = IDLE;
                    mm_d    = 8'h00;
                    ss_d    = 8'h00;
                end else if (load) begin
                    state_d = IDLE;
                    mm_d    = load_mm_clean;
                    ss_d    = load_ss_clean;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef TIMER_DONE_BLINK_EN
    localparam int BLINK_DIV = TICK_DIV / 2;

    if (TICK_DIV % 2 != 0) begin : g_bad_blink_ratio
        $error("timer_ctrl: blink needs an even CLK_HZ/TICK_HZ ratio");
    end

    logic blink_q, blink_d;
    logic blink_tick;
    logic blink_clr;

    assign blink_clr = (state_d == DONE) && (state_q != DONE);

    tick_gen #(.DIV(BLINK_DIV)) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == DONE),
        .clr   (blink_clr),
        .tick  (blink_tick)
    );

    // Entry to DONE always starts in the visible half.
    always_comb begin
        blink_d = blink_q;
        if (blink_clr) begin
            blink_d = 1'b0;
        end else if (blink_tick) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blank = (state_d == DONE) && blink_d;
`else
    assign blank = 1'b0;
`endif

    // Anode and digit are built from next-cycle values so they stay aligned with mm/ss.
    always_comb begin
        idx_d     = scan_tick ? idx_q + 2'd1 : idx_q;
        an_d      = AN_SS_ONES;
        digit_d   = ss_d[3:0];
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
        case (idx_d)
            2'd0: begin
                an_d    = AN_SS_ONES;
                digit_d = ss_d[3:0];
            end
            2'd1: begin
                an_d    = AN_SS_TENS;
                digit_d = ss_d[7:4];
            end
            2'd2: begin
                an_d    = AN_MM_ONES;
                digit_d = mm_d[3:0];
            end
            default: begin
                an_d    = AN_MM_TENS;
                digit_d = mm_d[7:4];
            end
        endcase
        if (blank) begin
            an_d = AN_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mm_q      <= 8'h00;
            ss_q      <= 8'h00;
            idx_q     <= 2'd0;
            an_q      <= AN_SS_ONES;
            digit_q   <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mm_q      <= mm_d;
            ss_q      <= ss_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            digit_q   <= digit_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign mm      = mm_q;
    assign ss      = ss_q;
    assign an      = an_q;
    assign digit   = digit_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl at CLK_HZ=20, TICK_HZ=1, SCAN_HZ=4:
// expectations are queued as stimulus is applied and popped when outputs are sampled.
module tb_timer_ctrl;

    localparam int CLK_HZ  = 20;
    localparam int TICK_HZ = 1;
    localparam int SCAN_HZ = 4;

    localparam logic [25:0] M_VAL  = {16'hFFFF, 10'h000};
    localparam logic [25:0] M_SCAN = {16'h0000, 8'hFF, 2'b00};
    localparam logic [25:0] M_FLAG = 26'h0000003;
    localparam logic [25:0] M_ALL  = 26'h3FFFFFF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, pause, clear, load;
    logic [7:0] load_mm, load_ss;
    logic [7:0] mm, ss;
    logic [3:0] an, digit;
    logic       running, done;
    logic [25:0] obsVec;

    typedef struct {
        string       tag;
        logic [25:0] mask;
        logic [25:0] exp;
    } exp_t;

    exp_t sbQueue[$];
    int   checks = 0;
    int   passes = 0;

    timer_ctrl #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .pause   (pause),
        .clear   (clear),
        .load    (load),
        .load_mm (load_mm),
        .load_ss (load_ss),
        .mm      (mm),
        .ss      (ss),
        .an      (an),
        .digit   (digit),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    assign obsVec = {mm, ss, an, digit, running, done};

    function automatic logic [25:0] packOut(input logic [7:0] m, input logic [7:0] s,
                                            input logic [3:0] a, input logic [3:0] d,
                                            input logic r, input logic dn);
        return {m, s, a, d, r, dn};
    endfunction

    task automatic checkOutput(input string tag, input logic [25:0] observed, input logic [25:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed %07h expected %07h (mm,ss,an,digit,run,done)",
                     tag, observed, expected);
        end
    endtask

    task automatic compareNext();
        exp_t e;
        if (sbQueue.size() == 0) begin
            checks++;
            $display("[TB] FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sbQueue.pop_front();
            checkOutput(e.tag, obsVec & e.mask, e.exp & e.mask);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Queue an expectation, let n cycles elapse, then compare at the negedge.
    task automatic checkAfter(input int n, input string tag, input logic [25:0] mask, input logic [25:0] exp);
        exp_t e;
        e.tag  = tag;
        e.mask = mask;
        e.exp  = exp;
        sbQueue.push_back(e);
        waitCycles(n);
        compareNext();
    endtask

    // Called at a negedge; pulses are sampled on the following posedge.
    task automatic applyStimulus(input logic doStart, input logic doPause, input logic doClear,
                                 input logic doLoad, input logic [7:0] lmm, input logic [7:0] lss);
        start   = doStart;
        pause   = doPause;
        clear   = doClear;
        load    = doLoad;
        load_mm = lmm;
        load_ss = lss;
        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        clear = 1'b0;
        load  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        pause   = 1'b0;
        clear   = 1'b0;
        load    = 1'b0;
        load_mm = 8'h00;
        load_ss = 8'h00;
        repeat (3) @(negedge clk);
        checkAfter(0, "reset", M_ALL, packOut(8'h00, 8'h00, 4'b1110, 4'd0, 1'b0, 1'b0));
        rst_n = 1'b1;

        $display("[TB] one-minute countdown");
        applyStimulus(0, 0, 0, 1, 8'h01, 8'h00);
        checkAfter(0, "load_0100", M_VAL | M_FLAG, packOut(8'h01, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
        checkAfter(0, "run_flag", M_FLAG, packOut(8'h00, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0));
        checkAfter(19, "pre_first_tick", M_VAL, packOut(8'h01, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        checkAfter(1, "first_tick", M_VAL, packOut(8'h00, 8'h59, 4'h0, 4'h0, 1'b0, 1'b0));
        checkAfter(1179, "pre_done", M_VAL | M_FLAG, packOut(8'h00, 8'h01, 4'h0, 4'h0, 1'b1, 1'b0));
        checkAfter(1, "done", M_VAL | M_FLAG, packOut(8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1));

        $display("[TB] minute borrow and load clamp");
        applyStimulus(0, 0, 1, 0, 8'h00, 8'h00);
        checkAfter(0, "clear_from_done", M_VAL | M_FLAG, packOut(8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        applyStimulus(0, 0, 0, 1, 8'h10, 8'h00);
        applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
        checkAfter(20, "mm_borrow", M_VAL, packOut(8'h09, 8'h59, 4'h0, 4'h0, 1'b0, 1'b0));
        applyStimulus(0, 0, 1, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 0, 1, 8'hAB, 8'h7C);
        checkAfter(0, "load_clamp", M_VAL, packOut(8'h99, 8'h59, 4'h0, 4'h0, 1'b0, 1'b0));
        applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
        applyStimulus(0, 0, 0, 1, 8'h11, 8'h11);
        checkAfter(0, "load_ignored_in_run", M_VAL | M_FLAG, packOut(8'h99, 8'h59, 4'h0, 4'h0, 1'b1, 1'b0));
        applyStimulus(0, 0, 1, 0, 8'h00, 8'h00);

        $display("[TB] pause and resume");
        applyStimulus(0, 0, 0, 1, 8'h00, 8'h05);
        applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
        checkAfter(40, "two_ticks", M_VAL, packOut(8'h00, 8'h03, 4'h0, 4'h0, 1'b0, 1'b0));
        applyStimulus(0, 1, 0, 0, 8'h00, 8'h00);
        checkAfter(0, "paused", M_VAL | M_FLAG, packOut(8'h00, 8'h03, 4'h0, 4'h0, 1'b0, 1'b0));
        checkAfter(100, "pause_hold", M_VAL, packOut(8'h00, 8'h03, 4'h0, 4'h0, 1'b0, 1'b0));
        applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
        checkAfter(19, "resume_pre_tick", M_VAL | M_FLAG, packOut(8'h00, 8'h03, 4'h0, 4'h0, 1'b1, 1'b0));
        checkAfter(1, "resume_tick", M_VAL, packOut(8'h00, 8'h02, 4'h0, 4'h0, 1'b0, 1'b0));

        $display("[TB] button priority");
        applyStimulus(1, 0, 1, 1, 8'h12, 8'h34);
        checkAfter(0, "clear_wins", M_VAL | M_FLAG, packOut(8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));
        applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
        checkAfter(25, "start_at_zero", M_VAL | M_FLAG, packOut(8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0));

        $display("[TB] anode scan");
        rst_n = 1'b0;
        waitCycles(2);
        rst_n   = 1'b1;
        load    = 1'b1;
        load_mm = 8'h12;
        load_ss = 8'h34;
        @(negedge clk);
        load = 1'b0;
        checkAfter(0, "scan_idx0", M_SCAN | M_VAL, packOut(8'h12, 8'h34, 4'b1110, 4'd4, 1'b0, 1'b0));
        checkAfter(3, "scan_idx0_hold", M_SCAN, packOut(8'h00, 8'h00, 4'b1110, 4'd4, 1'b0, 1'b0));
        checkAfter(1, "scan_idx1", M_SCAN, packOut(8'h00, 8'h00, 4'b1101, 4'd3, 1'b0, 1'b0));
        checkAfter(5, "scan_idx2", M_SCAN, packOut(8'h00, 8'h00, 4'b1011, 4'd2, 1'b0, 1'b0));
        checkAfter(5, "scan_idx3", M_SCAN, packOut(8'h00, 8'h00, 4'b0111, 4'd1, 1'b0, 1'b0));
        checkAfter(5, "scan_wrap", M_SCAN, packOut(8'h00, 8'h00, 4'b1110, 4'd4, 1'b0, 1'b0));

`ifdef TIMER_DONE_BLINK_EN
        $display("[TB] done blink");
        rst_n = 1'b0;
        waitCycles(2);
        rst_n   = 1'b1;
        load    = 1'b1;
        load_mm = 8'h00;
        load_ss = 8'h01;
        @(negedge clk);
        load = 1'b0;
        applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
        checkAfter(20, "blink_enter", M_SCAN | M_FLAG, packOut(8'h00, 8'h00, 4'b1110, 4'd0, 1'b0, 1'b1));
        checkAfter(9, "blink_visible", M_SCAN, packOut(8'h00, 8'h00, 4'b1011, 4'd0, 1'b0, 1'b0));
        checkAfter(1, "blink_off", M_SCAN, packOut(8'h00, 8'h00, 4'b1111, 4'd0, 1'b0, 1'b0));
        checkAfter(9, "blink_off_hold", M_SCAN, packOut(8'h00, 8'h00, 4'b1111, 4'd0, 1'b0, 1'b0));
        checkAfter(1, "blink_on", M_SCAN, packOut(8'h00, 8'h00, 4'b1110, 4'd0, 1'b0, 1'b0));
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
